// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin index arbiter.
//   state_t        : arbiter FSM states (IDLE, OFFER, HOLD)
//   RR_IDX_W_DEF   : default grant index width (N = 2**IDX_W requesters)
//   RR_CNT_W       : width of the post-grant dwell counter (dwell 0..15)
package rr_arb_pkg;

  localparam int unsigned RR_IDX_W_DEF = 3;
  localparam int unsigned RR_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority search.
// Returns the first set request bit at (ptr+1), (ptr+2), ... mod N, so the
// requester at ptr itself has the lowest priority.
//   req   : request vector, bit i = requester i
//   ptr   : index granted last (search starts just after it)
//   idx   : selected requester index (0 when nothing found)
//   found : at least one request bit is set
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned IDX_W = RR_IDX_W_DEF
) (
  input  logic [2**IDX_W-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [IDX_W-1:0]    idx,
  output logic                found
);

  localparam int unsigned N = 2**IDX_W;

  logic [IDX_W-1:0] w_cand;

  // Offset N wraps to ptr itself, giving the last-granted requester a turn
  // only when nobody else is asking.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = ptr + IDX_W'(k);
      if (!found && req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_index_arb.sv
// Round-robin arbiter over N = 2**IDX_W request lines with a registered
// binary grant index and a valid/ready handshake. The index feeds a one-hot
// decoder downstream; offers are sticky until accepted.
//   clk       : rising-edge clock
//   n_reset   : asynchronous active-low reset
//   req       : level-sensitive request lines
//   gnt_valid : gnt_idx holds a grant offer
//   gnt_ready : consumer accepts the offer (handshake = valid & ready)
//   gnt_idx   : granted requester index
//   busy      : FSM is outside IDLE
//   lock      : only with RR_LOCK_EN defined; a handshake with lock=1
//               re-offers the same index and leaves the pointer untouched
// Parameters: IDX_W (index width), HOLD_CYC (idle cycles after each
// accepted grant, 0..15).
module rr_index_arb
  import rr_arb_pkg::*;
#(
  parameter int unsigned IDX_W    = RR_IDX_W_DEF,
  parameter int unsigned HOLD_CYC = 0
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [2**IDX_W-1:0] req,
  output logic                gnt_valid,
  input  logic                gnt_ready,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic                busy
`ifdef RR_LOCK_EN
  ,
  input  logic                lock
`endif
);

  // Counter is loaded with HOLD_CYC-1 and HOLD exits on zero, giving exactly
  // HOLD_CYC cycles in HOLD before the IDLE cycle.
  localparam logic [RR_CNT_W-1:0] HOLD_LD =
    (HOLD_CYC > 0) ? RR_CNT_W'(HOLD_CYC - 1) : '0;

  state_t                r_state;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_valid;
  logic [RR_CNT_W-1:0]   r_cnt;

  logic                  w_hs;
  logic                  w_lock;
  logic [IDX_W-1:0]      w_pick_ptr;
  logic [IDX_W-1:0]      w_pick_idx;
  logic                  w_pick_found;

  assign w_hs = r_valid & gnt_ready;

`ifdef RR_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  // In OFFER the search must start after the index being accepted this
  // cycle, before r_ptr has caught up, so the single picker serves both the
  // IDLE pick and the back-to-back re-pick.
  assign w_pick_ptr = (r_state == OFFER) ? r_idx : r_ptr;

  rr_pick #(
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (w_pick_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '1;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_found) begin
            r_idx   <= w_pick_idx;
            r_valid <= 1'b1;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (w_hs && !w_lock) begin
            r_ptr <= r_idx;
            if (HOLD_CYC > 0) begin
              r_valid <= 1'b0;
              r_cnt   <= HOLD_LD;
              r_state <= HOLD;
            end else if (w_pick_found) begin
              r_idx <= w_pick_idx;
            end else begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - RR_CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_valid = r_valid;
  assign gnt_idx   = r_idx;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rr_index_arb.sv
module tb_rr_index_arb;

  localparam int N = 8;
  localparam int HOLDS [2] = '{0, 2};

  logic       clk     = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] req0    = '0;
  logic [7:0] req1    = '0;
  logic       rdy0    = 1'b0;
  logic       rdy1    = 1'b0;
  logic       lk0     = 1'b0;
  logic       v0, v1, b0, b1;
  logic [2:0] i0, i1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: last accepted index, current offer, dwell left.
  int m_ptr   [2];
  int m_idx   [2];
  int m_hold  [2];
  bit m_valid [2];

  always #5 clk = ~clk;

  rr_index_arb #(.IDX_W(3), .HOLD_CYC(0)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .req       (req0),
    .gnt_valid (v0),
    .gnt_ready (rdy0),
    .gnt_idx   (i0),
    .busy      (b0)
`ifdef RR_LOCK_EN
    ,
    .lock      (lk0)
`endif
  );

  rr_index_arb #(.IDX_W(3), .HOLD_CYC(2)) dut_h (
    .clk       (clk),
    .n_reset   (n_reset),
    .req       (req1),
    .gnt_valid (v1),
    .gnt_ready (rdy1),
    .gnt_idx   (i1),
    .busy      (b1)
`ifdef RR_LOCK_EN
    ,
    .lock      (1'b0)
`endif
  );

  // Round-robin rule: scan (p+1), (p+2), ... mod N; -1 when no request.
  function automatic int pick(input logic [7:0] r, input int p);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit m_busy(input int d);
    return m_valid[d] || (m_hold[d] > 0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = N - 1; m_idx[d] = 0; m_hold[d] = 0; m_valid[d] = 1'b0;
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    logic [7:0] r;
    bit rd, lk;
    int k;
    for (int d = 0; d < 2; d++) begin
      r  = (d == 0) ? req0 : req1;
      rd = (d == 0) ? rdy0 : rdy1;
`ifdef RR_LOCK_EN
      lk = (d == 0) ? lk0 : 1'b0;
`else
      lk = 1'b0;
`endif
      if (m_valid[d] && rd) begin
        if (!lk) begin
          m_ptr[d] = m_idx[d];
          if (HOLDS[d] > 0) begin
            m_valid[d] = 1'b0;
            m_hold[d]  = HOLDS[d];
          end else begin
            k = pick(r, m_ptr[d]);
            if (k >= 0) m_idx[d] = k;
            else        m_valid[d] = 1'b0;
          end
        end
      end else if (m_hold[d] > 0) begin
        m_hold[d]--;
      end else if (!m_valid[d]) begin
        k = pick(r, m_ptr[d]);
        if (k >= 0) begin
          m_idx[d]   = k;
          m_valid[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    req0 = '0; req1 = '0; rdy0 = 1'b0; rdy1 = 1'b0; lk0 = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (v0 !== 1'b0 || i0 !== 3'd0 || b0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset dut: valid=%b idx=%0d busy=%b, expected 0 0 0", v0, i0, b0);
    end
    n_chk++;
    if (v1 !== 1'b0 || i1 !== 3'd0 || b1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset dut_h: valid=%b idx=%0d busy=%b, expected 0 0 0", v1, i1, b1);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++;
      if (v0 !== 1'b0 || b0 !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_req[%0d]: valid=%b busy=%b, expected 0 0", c, v0, b0);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req0 = 8'hFF; rdy0 = 1'b1;
    tick(); tick(); tick();
    rdy0 = 1'b0;
    n_chk++;
    if (v0 !== 1'b1 || i0 !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_setup: valid=%b idx=%0d, expected 1 2", v0, i0);
    end
    #2;
    n_reset = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (v0 !== 1'b0 || i0 !== 3'd0 || b0 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b idx=%0d busy=%b, expected 0 0 0", v0, i0, b0);
    end
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    tick();
    n_chk++;
    if (v0 !== 1'b1 || i0 !== 3'd0) begin
      n_fail++;
      $display("FAIL first_after_reset: valid=%b idx=%0d, expected 1 0", v0, i0);
    end
  endtask

  task automatic test_rotate();
    apply_reset();
    req0 = 8'hFF; rdy0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_chk++;
      if (v0 !== 1'b1 || i0 !== 3'(i) || i0 !== 3'(m_idx[0])) begin
        n_fail++;
        $display("FAIL rotate[%0d]: valid=%b idx=%0d, expected 1 %0d", i, v0, i0, i % 8);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_i [4] = '{2, 7, 2, 7};
    apply_reset();
    req0 = 8'b1000_0100; rdy0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (v0 !== 1'b1 || i0 !== 3'(exp_i[i])) begin
        n_fail++;
        $display("FAIL wrap[%0d]: valid=%b idx=%0d, expected 1 %0d", i, v0, i0, exp_i[i]);
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    req0 = 8'h10; rdy0 = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i >= 3) req0 = 8'h00;
      tick();
      n_chk++;
      if (v0 !== 1'b1 || i0 !== 3'd4 || b0 !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d]: valid=%b idx=%0d busy=%b, expected 1 4 1", i, v0, i0, b0);
      end
    end
    req0 = 8'h01; rdy0 = 1'b1;
    tick();
    n_chk++;
    if (v0 !== 1'b1 || i0 !== 3'd0) begin
      n_fail++;
      $display("FAIL after_stall: valid=%b idx=%0d, expected 1 0", v0, i0);
    end
    req0 = 8'h00;
    tick();
    n_chk++;
    if (v0 !== 1'b0 || b0 !== 1'b0 || i0 !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_idle: valid=%b busy=%b idx=%0d, expected 0 0 0", v0, b0, i0);
    end
  endtask

  task automatic test_hold();
    bit ev [6] = '{1, 0, 0, 0, 1, 0};
    bit eb [6] = '{1, 1, 1, 0, 1, 1};
    int ei [6] = '{0, 0, 0, 0, 1, 1};
    apply_reset();
    req1 = 8'h03; rdy1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (v1 !== ev[i] || b1 !== eb[i] || i1 !== 3'(ei[i])) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b busy=%b idx=%0d, expected %b %b %0d",
                 i, v1, b1, i1, ev[i], eb[i], ei[i]);
      end
    end
  endtask

`ifdef RR_LOCK_EN
  task automatic test_lock();
    apply_reset();
    req0 = 8'h08; rdy0 = 1'b0;
    tick();
    n_chk++;
    if (v0 !== 1'b1 || i0 !== 3'd3) begin
      n_fail++;
      $display("FAIL lock_setup: valid=%b idx=%0d, expected 1 3", v0, i0);
    end
    req0 = 8'hFF; rdy0 = 1'b1; lk0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (v0 !== 1'b1 || i0 !== 3'd3) begin
        n_fail++;
        $display("FAIL lock_hold[%0d]: valid=%b idx=%0d, expected 1 3", i, v0, i0);
      end
    end
    lk0 = 1'b0;
    tick();
    n_chk++;
    if (v0 !== 1'b1 || i0 !== 3'd4) begin
      n_fail++;
      $display("FAIL lock_release: valid=%b idx=%0d, expected 1 4", v0, i0);
    end
  endtask
`endif

  task automatic test_random();
    int sel;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 3);
      req0 = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      sel = $urandom_range(0, 3);
      req1 = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      rdy0 = 1'($urandom_range(0, 1));
      rdy1 = 1'($urandom_range(0, 1));
`ifdef RR_LOCK_EN
      lk0 = ($urandom_range(0, 3) == 0);
`endif
      tick();
      n_chk++;
      if (v0 !== m_valid[0] || i0 !== 3'(m_idx[0]) || b0 !== m_busy(0)) begin
        n_fail++;
        $display("FAIL random dut[%0d]: valid=%b idx=%0d busy=%b, expected %b %0d %b",
                 c, v0, i0, b0, m_valid[0], m_idx[0], m_busy(0));
      end
      n_chk++;
      if (v1 !== m_valid[1] || i1 !== 3'(m_idx[1]) || b1 !== m_busy(1)) begin
        n_fail++;
        $display("FAIL random dut_h[%0d]: valid=%b idx=%0d busy=%b, expected %b %0d %b",
                 c, v1, i1, b1, m_valid[1], m_idx[1], m_busy(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_rotate();
    test_wrap();
    test_stall();
    test_hold();
`ifdef RR_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
